// File: rtl/spi_slave_frontend.sv
// SPI slave front-end: shifts 10-bit MOSI command words in to the RAM and shifts RAM read data out on MISO.
// Optional macro SPI_FRAME_ERR_EN adds the frame_err abort strobe.
module spi_slave_frontend #(
    parameter int WORD_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
`ifdef SPI_FRAME_ERR_EN
    output logic              frame_err,
`endif
    output logic [2:0]        state_dbg,
    output logic              rd_flag_dbg
);

    // Handshake: rx_valid and tx_valid are single-cycle strobes without backpressure;
    // the receiver must take the data in the strobe cycle, there is no ready.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam int TCNT_W = $clog2(DATA_W + 1);
    localparam logic [BCNT_W-1:0] BITS_LAST = BCNT_W'(WORD_W - 1);
    localparam logic [BCNT_W-1:0] BITS_ALL  = BCNT_W'(WORD_W);
    localparam logic [TCNT_W-1:0] TX_ALL    = TCNT_W'(DATA_W);

    state_t            state, next_state;
    logic [BCNT_W-1:0] bit_cnt;
    logic [WORD_W-1:0] rx_shift;
    logic [DATA_W-1:0] tx_shift;
    logic [TCNT_W-1:0] tx_cnt;
    logic              tx_busy, tx_done, rd_flag;
    logic              leaving, rx_active, tx_wait;

    assign state_dbg   = state;
    assign rd_flag_dbg = rd_flag;

    always_comb begin
        next_state = state;
        leaving    = (state != IDLE) && SS_n;
        rx_active  = ((state == WRITE) || (state == READ_ADD) || (state == READ_DATA))
                     && (bit_cnt != BITS_ALL);
        tx_wait    = (state == READ_DATA) && (bit_cnt == BITS_ALL) && !tx_busy && !tx_done;
        case (state)
            IDLE: begin
                if (!SS_n) next_state = CHK_CMD;
            end
            CHK_CMD: begin
                if (SS_n)         next_state = IDLE;
                else if (!MOSI)   next_state = WRITE;
                else if (!rd_flag) next_state = READ_ADD;
                else              next_state = READ_DATA;
            end
            default: begin
                if (SS_n) next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_shift <= '0;
            tx_cnt   <= '0;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            rd_flag  <= 1'b0;
            MISO     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (leaving) begin
                // Frame end or abort; rd_flag deliberately survives an aborted read.
                bit_cnt <= '0;
                tx_cnt  <= '0;
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
                MISO    <= 1'b0;
            end else if (state == CHK_CMD) begin
                rx_shift <= {{(WORD_W-1){1'b0}}, MOSI};
                bit_cnt  <= BCNT_W'(1);
            end else if (rx_active) begin
                rx_shift <= {rx_shift[WORD_W-2:0], MOSI};
                bit_cnt  <= bit_cnt + 1'b1;
                if (bit_cnt == BITS_LAST) begin
                    rx_data  <= {rx_shift[WORD_W-2:0], MOSI};
                    rx_valid <= 1'b1;
                    if (state == READ_ADD) rd_flag <= 1'b1;
                end
            end else if (tx_wait && tx_valid) begin
                MISO     <= tx_data[DATA_W-1];
                tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                tx_cnt   <= TCNT_W'(1);
                tx_busy  <= 1'b1;
            end else if (tx_busy) begin
                if (tx_cnt == TX_ALL) begin
                    MISO    <= 1'b0;
                    tx_busy <= 1'b0;
                    tx_done <= 1'b1;
                    rd_flag <= 1'b0;
                end else begin
                    MISO     <= tx_shift[DATA_W-1];
                    tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
                    tx_cnt   <= tx_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SPI_FRAME_ERR_EN
    logic early_abort;

    // A frame is short if the command word is incomplete or read data is still owed.
    assign early_abort = (state == CHK_CMD) || rx_active || ((state == READ_DATA) && !tx_done);

    always_ff @(posedge clk) begin
        if (rst) frame_err <= 1'b0;
        else     frame_err <= leaving && early_abort;
    end
`endif

endmodule
